// File: rtl/seq_alu_if.sv
// Request/result handshake bundle for seq_alu.
// The slave modport is the ALU side; the master modport is the requester/consumer side.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_overflow;
    logic             flag_div0;

    modport slave (
        input  in_valid, opcode, operand1, operand2, out_ready,
        output in_ready, out_valid, result, result_hi,
        output flag_zero, flag_carry, flag_overflow, flag_div0
    );

    modport master (
        output in_valid, opcode, operand1, operand2, out_ready,
        input  in_ready, out_valid, result, result_hi,
        input  flag_zero, flag_carry, flag_overflow, flag_div0
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops, plus an iterative shift-add
// multiplier and a restoring divider. Each takes one step per cycle.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    seq_alu_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL1 = 4'h4;
    localparam logic [3:0] OP_SHR1 = 4'h5;
    localparam logic [3:0] OP_ROL1 = 4'h6;
    localparam logic [3:0] OP_ROR1 = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             div0_q, div0_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Iteration datapath: a = multiplicand/divisor, b = multiplier/dividend
    // (becomes product low half / quotient), acc = product high half / remainder.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic signed [WIDTH-1:0] op1_s, op2_s, sc_res_s;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nx;
    logic [WIDTH-1:0] div_quo_nx;

    assign op1_s = $signed(bus.operand1);
    assign op2_s = $signed(bus.operand2);

    always_comb begin
        sum_ext  = '0;
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                sum_ext  = {1'b0, bus.operand1} + {1'b0, bus.operand2};
                sc_res   = sum_ext[WIDTH-1:0];
                sc_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                sum_ext  = {1'b0, bus.operand1} - {1'b0, bus.operand2};
                sc_res   = sum_ext[WIDTH-1:0];
                sc_carry = sum_ext[WIDTH];
            end
            OP_SHL1: begin
                sc_res   = {bus.operand1[WIDTH-2:0], 1'b0};
                sc_carry = bus.operand1[WIDTH-1];
            end
            OP_SHR1: begin
                sc_res   = {1'b0, bus.operand1[WIDTH-1:1]};
                sc_carry = bus.operand1[0];
            end
            OP_ROL1: begin
                sc_res   = {bus.operand1[WIDTH-2:0], bus.operand1[WIDTH-1]};
                sc_carry = bus.operand1[WIDTH-1];
            end
            OP_ROR1: begin
                sc_res   = {bus.operand1[0], bus.operand1[WIDTH-1:1]};
                sc_carry = bus.operand1[0];
            end
            OP_AND:  sc_res = bus.operand1 & bus.operand2;
            OP_OR:   sc_res = bus.operand1 | bus.operand2;
            OP_XOR:  sc_res = bus.operand1 ^ bus.operand2;
            OP_NOR:  sc_res = ~(bus.operand1 | bus.operand2);
            OP_NAND: sc_res = ~(bus.operand1 & bus.operand2);
            OP_XNOR: sc_res = ~(bus.operand1 ^ bus.operand2);
            OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (bus.operand1 > bus.operand2)};
            OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (bus.operand1 == bus.operand2)};
            default: sc_res = '0;
        endcase
        sc_res_s = $signed(sc_res);
        // Signed overflow: operand signs agree (ADD) or differ (SUB) and the result sign flips.
        if (bus.opcode == OP_ADD)
            sc_ovf = ((op1_s < 0) == (op2_s < 0)) && ((sc_res_s < 0) != (op1_s < 0));
        else if (bus.opcode == OP_SUB)
            sc_ovf = ((op1_s < 0) != (op2_s < 0)) && ((sc_res_s < 0) != (op1_s < 0));
    end

    always_comb begin
        mul_sum    = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_hi_nx  = mul_sum[WIDTH:1];
        mul_lo_nx  = {mul_sum[0], b_q[WIDTH-1:1]};
        div_shift  = {acc_q, b_q[WIDTH-1]};
        div_diff   = div_shift - {1'b0, a_q};
        div_ge     = ~div_diff[WIDTH];
        div_rem_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_nx = {b_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        div0_d      = div0_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    in_ready_d = 1'b0;
                    cnt_d      = '0;
                    acc_d      = '0;
                    if (bus.opcode == OP_MUL) begin
                        a_d     = bus.operand1;
                        b_d     = bus.operand2;
                        state_d = MUL;
                    end else if (bus.opcode == OP_DIV && bus.operand2 != '0) begin
                        a_d     = bus.operand2;
                        b_d     = bus.operand1;
                        state_d = DIV;
                    end else if (bus.opcode == OP_DIV) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = '1;
                        result_hi_d = bus.operand1;
                        zero_d      = 1'b0;
                        carry_d     = 1'b0;
                        ovf_d       = 1'b0;
                        div0_d      = 1'b1;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = sc_res;
                        result_hi_d = '0;
                        zero_d      = (sc_res == '0);
                        carry_d     = sc_carry;
                        ovf_d       = sc_ovf;
                        div0_d      = 1'b0;
                    end
                end
            end
            MUL: begin
                acc_d = mul_hi_nx;
                b_d   = mul_lo_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = mul_lo_nx;
                    result_hi_d = mul_hi_nx;
                    zero_d      = (mul_lo_nx == '0);
                    carry_d     = 1'b0;
                    ovf_d       = (mul_hi_nx != '0);
                    div0_d      = 1'b0;
                end
            end
            DIV: begin
                acc_d = div_rem_nx;
                b_d   = div_quo_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = div_quo_nx;
                    result_hi_d = div_rem_nx;
                    zero_d      = (div_quo_nx == '0);
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    div0_d      = 1'b0;
                end
            end
            DONE: begin
                // Retiring edge only returns to IDLE; a new request waits one more edge.
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            div0_q      <= div0_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.result        = result_q;
    assign bus.result_hi     = result_hi_q;
    assign bus.flag_zero     = zero_q;
    assign bus.flag_carry    = carry_q;
    assign bus.flag_overflow = ovf_q;
    assign bus.flag_div0     = div0_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu at WIDTH=16 with hand-computed expected values.
module tb_seq_alu;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;
    logic rdy_seen;
    logic ov_seen;

    // Sweep expectations for operand1=0x8001, operand2=0x0003; flags are {zero,carry,ovf,div0}.
    logic [15:0] sw_res [0:15] = '{16'h8004, 16'h7FFE, 16'h8003, 16'h2AAB,
                                   16'h0002, 16'h4000, 16'h0003, 16'hC000,
                                   16'h0001, 16'h8003, 16'h8002, 16'h7FFC,
                                   16'hFFFE, 16'h7FFD, 16'h0001, 16'h0000};
    logic [15:0] sw_hi  [0:15] = '{16'h0, 16'h0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                                   16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [3:0]  sw_flg [0:15] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                   4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                   4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0000, 4'b0000, 4'b0000, 4'b1000};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.flag_zero, bus.flag_carry, bus.flag_overflow, bus.flag_div0};
    endfunction

    // Called #1 after a posedge with the DUT idle; returns when out_valid is seen or the bound expires.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.opcode   = op;
        bus.operand1 = a;
        bus.operand2 = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat      = 1;
        rdy_seen = bus.in_ready;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            rdy_seen = rdy_seen | bus.in_ready;
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] res, input logic [15:0] hi,
                              input logic [3:0] flg, input int exp_lat);
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_res"}, 64'(bus.result), 64'(res));
        check_val({tag, "_hi"}, 64'(bus.result_hi), 64'(hi));
        check_val({tag, "_flags"}, 64'(flags()), 64'(flg));
    endtask

    task automatic retire(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val({tag, "_retire_rdy"}, 64'(bus.in_ready), 64'd1);
        check_val({tag, "_retire_vld"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'h0;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_result", 64'(bus.result), 64'd0);
        check_val("rst_result_hi", 64'(bus.result_hi), 64'd0);
        check_val("rst_flags", 64'(flags()), 64'd0);

        issue(4'h0, 16'hFFFF, 16'h0001);
        expect_out("add_wrap", 16'h0000, 16'h0000, 4'b1100, 1);
        retire("add_wrap");

        issue(4'h0, 16'h7FFF, 16'h0001);
        expect_out("add_ovf", 16'h8000, 16'h0000, 4'b0010, 1);
        retire("add_ovf");

        issue(4'h2, 16'h1234, 16'h0100);
        expect_out("mul", 16'h3400, 16'h0012, 4'b0010, 17);
        check_val("mul_in_ready_low", 64'(rdy_seen), 64'd0);
        retire("mul");

        issue(4'h3, 16'd100, 16'd7);
        expect_out("div", 16'h000E, 16'h0002, 4'b0000, 17);
        retire("div");

        issue(4'h3, 16'h1234, 16'h0000);
        expect_out("div0", 16'hFFFF, 16'h1234, 4'b0001, 1);
        retire("div0");

        // Backpressure: result must hold while stray requests are offered.
        issue(4'h1, 16'h0000, 16'h0001);
        expect_out("sub_bp", 16'hFFFF, 16'h0000, 4'b0100, 1);
        for (int i = 0; i < 5; i++) begin
            bus.opcode   = 4'h0;
            bus.operand1 = 16'h0011;
            bus.operand2 = 16'h0022;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_val("bp_valid", 64'(bus.out_valid), 64'd1);
            check_val("bp_result", 64'(bus.result), 64'hFFFF);
            check_val("bp_flags", 64'(flags()), 64'b0100);
            check_val("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        retire("sub_bp");
        @(posedge clk);
        #1;
        check_val("bp_no_phantom", 64'(bus.out_valid), 64'd0);

        // Reset eight cycles into a multiply.
        bus.opcode   = 4'h2;
        bus.operand1 = 16'h1234;
        bus.operand2 = 16'h0100;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_val("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("mrst_result", 64'(bus.result), 64'd0);
        check_val("mrst_result_hi", 64'(bus.result_hi), 64'd0);
        check_val("mrst_flags", 64'(flags()), 64'd0);
        ov_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            ov_seen = ov_seen | bus.out_valid;
        end
        check_val("mrst_no_result", 64'(ov_seen), 64'd0);
        issue(4'h0, 16'd2, 16'd3);
        expect_out("post_rst_add", 16'h0005, 16'h0000, 4'b0000, 1);
        retire("post_rst_add");

        for (int op = 0; op < 16; op++) begin
            issue(4'(op), 16'h8001, 16'h0003);
            expect_out($sformatf("sweep_op%0h", op), sw_res[op], sw_hi[op], sw_flg[op],
                       (op == 2 || op == 3) ? 17 : 1);
            retire($sformatf("sweep_op%0h", op));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand/result width; legal range 4..64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, with reset synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, request present.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have port opcode, input, 4, operation select per REQ-012.
REQ-007 The block SHALL have ports operand1 and operand2, input, WIDTH each, the source operands.
REQ-008 The block SHALL have port out_valid, output, 1, result present.
REQ-009 The block SHALL have port out_ready, input, 1, consumer takes result.
REQ-010 The block SHALL have ports result and result_hi, output, WIDTH each: primary result, and upper product half / remainder.
REQ-011 The block SHALL have ports flag_zero, flag_carry, flag_overflow and flag_div0, output, 1 each, the status flags.

Function
REQ-012 Opcode map SHALL be:
- 0 ADD, 1 SUB, 2 MUL, 3 DIV (unsigned).
- 4 SHL1, 5 SHR1, 6 ROL1, 7 ROR1.
- 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR.
- E GT (unsigned, result 1/0), F EQ (result 1/0).
REQ-013 The FSM SHALL have states IDLE, MUL, DIV and DONE; in_ready=1 only in IDLE.
REQ-014 A request SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; opcode and operands are captured at that edge and the ports are ignored thereafter.
REQ-015 Single-cycle ops, and DIV with operand2=0, SHALL go IDLE->DONE at acceptance; out_valid=1 in the cycle after the accept edge (latency 1).
REQ-016 MUL SHALL go IDLE->MUL, iterate one shift-add step per cycle for exactly WIDTH cycles, then ->DONE; out_valid rises WIDTH+1 cycles after the accept edge.
REQ-017 DIV with operand2!=0 SHALL go IDLE->DIV, iterate one restoring step per cycle for exactly WIDTH cycles, then ->DONE; same latency as MUL.
REQ-018 In DONE, out_valid=1 and result, result_hi and all flags SHALL be held stable until a rising edge with out_ready=1, which returns the FSM to IDLE.
REQ-019 A new request SHALL not be accepted at the same edge that retires a result; the minimum issue interval is 2 cycles.
REQ-020 ADD/SUB results SHALL be taken modulo 2^WIDTH.
- flag_carry = carry-out on ADD, borrow on SUB.
- flag_overflow = two's-complement signed overflow.
REQ-021 MUL SHALL place the low half of the 2*WIDTH product in result and the high half in result_hi; flag_overflow=1 iff result_hi!=0.
REQ-022 DIV SHALL place the quotient in result and the remainder in result_hi.
REQ-023 DIV with operand2=0 SHALL give result all-ones, result_hi=operand1, flag_div0=1.
REQ-024 Shifts and rotates SHALL set flag_carry to the bit moved out of the MSB (SHL1/ROL1) or LSB (SHR1/ROR1); they shift in zero (SHL1/SHR1) or rotate (ROL1/ROR1).
REQ-025 flag_zero SHALL equal (result==0) for every op.
- flag_carry, flag_overflow and flag_div0 SHALL be 0 wherever not defined above.
- For ops other than MUL and DIV, result_hi SHALL be 0.

Reset
REQ-026 With reset_n=0 at a rising edge, the block SHALL go to IDLE and clear result, result_hi, all flags, out_valid and the iteration counter; in_ready=1 from the next cycle.
REQ-027 Reset in MUL, DIV or DONE SHALL abort the operation with no result ever presented; reset has priority over every other event at that edge.

Verification (WIDTH=16)
REQ-028 ADD 0xFFFF+0x0001 -> result 0x0000, flag_zero=1, flag_carry=1, out_valid 1 cycle after accept; ADD 0x7FFF+0x0001 -> result 0x8000, flag_overflow=1.
REQ-029 MUL 0x1234*0x0100 -> result 0x3400, result_hi 0x0012, flag_overflow=1, out_valid exactly 17 cycles after accept, in_ready=0 throughout.
REQ-030 DIV 100/7 -> result 0x000E, result_hi 0x0002, 17-cycle latency; DIV 0x1234/0 -> result 0xFFFF, result_hi 0x1234, flag_div0=1, 1-cycle latency.
REQ-031 Backpressure: SUB 0x0000-0x0001, out_ready held 0 for 5 cycles -> result 0xFFFF, flag_carry=1, stable for all 5 cycles; in_valid pulses in that window are ignored; retire on the out_ready=1 edge, in_ready=1 the next cycle.
REQ-032 Reset mid-MUL: reset_n=0 for one edge 8 cycles after accept -> out_valid stays 0, all outputs 0, in_ready=1 the next cycle; a following ADD 2+3 returns 0x0005 normally.
REQ-033 Sweep all 16 opcodes with operand1=0x8001, operand2=0x0003 -> each result and flag matches a reference model, including ROL1 result 0x0003 with flag_carry=1 and ROR1 result 0xC000 with flag_carry=1.
